// File: rtl/shiftreg_responder_if.sv
// Controller-side link of the emulated 74HC165 chain: serial clock and load
// strobe from the controller, serial data back from the responder.
interface shiftreg_responder_if;
  logic shiftreg_clk;
  logic shiftreg_loadn;
  logic shiftreg_out;

  modport master (
    output shiftreg_clk,
    output shiftreg_loadn,
    input  shiftreg_out
  );

  modport slave (
    input  shiftreg_clk,
    input  shiftreg_loadn,
    output shiftreg_out
  );
endinterface

// File: rtl/shiftreg_responder.sv
// Oversampled emulation of a parallel-in/serial-out button shift register chain,
// shifting MSB first and flagging completed and aborted frames.
module shiftreg_responder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             buttons,
  input  logic                         ser_in,
  shiftreg_responder_if.slave          bus,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         frame_done,
  output logic                         short_frame
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] FULL     = CW'(WIDTH);
  localparam logic [AW-1:0] ARM_INIT = AW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] loadn_sync;
  logic [SYNC_STAGES-1:0] ser_sync;
  logic [WIDTH-1:0]       btn_sync [SYNC_STAGES];

  logic                   sync_clk;
  logic                   sync_loadn;
  logic                   sync_ser_in;
  logic [WIDTH-1:0]       sync_buttons;

  logic                   prev_clk;
  logic                   prev_loadn;
  logic [AW-1:0]          arm_cnt;
  logic                   armed;
  logic [WIDTH-1:0]       sreg;

  logic                   clk_rise;
  logic                   load_fall;

  assign sync_clk     = clk_sync[SYNC_STAGES-1];
  assign sync_loadn   = loadn_sync[SYNC_STAGES-1];
  assign sync_ser_in  = ser_sync[SYNC_STAGES-1];
  assign sync_buttons = btn_sync[SYNC_STAGES-1];

  assign clk_rise  = armed & sync_clk & ~prev_clk;
  assign load_fall = armed & ~sync_loadn & prev_loadn;

  assign bus.shiftreg_out = sreg[WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= '0;
      loadn_sync <= '1;
      ser_sync   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) btn_sync[i] <= '0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.shiftreg_clk};
      loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], bus.shiftreg_loadn};
      ser_sync   <= {ser_sync[SYNC_STAGES-2:0], ser_in};
      btn_sync[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) btn_sync[i] <= btn_sync[i-1];
    end
  end

  // Arming holds off edge detection until the synchronisers have flushed
  // their reset values, so a line already high at reset is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= ARM_INIT;
      armed   <= 1'b0;
    end else begin
      if (arm_cnt != '0) arm_cnt <= arm_cnt - AW'(1);
      if (arm_cnt == AW'(1)) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_clk    <= 1'b0;
      prev_loadn  <= 1'b1;
      sreg        <= '0;
      bit_count   <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      prev_clk    <= sync_clk;
      prev_loadn  <= sync_loadn;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      if (armed && !sync_loadn) begin
        // Load dominates: any clock edge seen while loading is dropped.
        sreg        <= sync_buttons;
        bit_count   <= '0;
        short_frame <= load_fall && (bit_count != '0) && (bit_count != FULL);
      end else if (clk_rise) begin
        sreg <= {sreg[WIDTH-2:0], sync_ser_in};
        if (bit_count != FULL) begin
          bit_count  <= bit_count + CW'(1);
          frame_done <= (bit_count == FULL - CW'(1));
        end
      end
    end
  end

endmodule
